iec_host_tx: RTL and testbench

Host-side IEC serial bus transmitter: the controller/talker end of the protocol the drive models answer as listeners. It serialises one byte at a time onto ATN/CLK/DATA, optionally under ATN for command bytes, with optional EOI signalling, and reports acknowledge or error status. It sits on the computer side of the bus and runs on the drive clock/ce domain (16 MHz, ce-qualified).

---
 rtl/iec_host_tx.sv | 262 ++++++++++++++++++++++++++
 tb/tb_iec_host_tx.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iec_host_tx.sv
// iec_host_tx: IEC serial bus talker/controller. Sends one byte per request on
// ATN/CLK/DATA (open-collector, 1 = released), optionally under ATN and with the
// EOI handshake, and reports the outcome on status with a one-clk done pulse.
module iec_host_tx #(
    parameter int CE_PER_US  = 16,
    parameter int T_BIT_US   = 60,
    parameter int T_ACK_US   = 1000,
    parameter int T_EOI_US   = 250,
    parameter int T_READY_US = 10000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [7:0] tx_data,
    input  logic       tx_atn,
    input  logic       tx_eoi,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       done,
    output logic [1:0] status,
    output logic       iec_atn_o,
    output logic       iec_clk_o,
    output logic       iec_data_o,
    input  logic       iec_clk_i,
    input  logic       iec_data_i
);

    localparam int PRE_W = (CE_PER_US > 1) ? $clog2(CE_PER_US) : 1;

    localparam logic [13:0] US_MAX  = 14'h3FFF;
    localparam logic [13:0] L_BIT   = 14'(T_BIT_US);
    localparam logic [13:0] L_ACK   = 14'(T_ACK_US);
    localparam logic [13:0] L_EOI   = 14'(T_EOI_US + T_ACK_US);
    localparam logic [13:0] L_READY = 14'(T_READY_US);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NODEV   = 2'b01;
    localparam logic [1:0] ST_NOACK   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_ATN_START, S_HOLD, S_READY, S_EOI_LOW, S_EOI_HIGH,
        S_BIT_LOW, S_BIT_HIGH, S_ACK_WAIT, S_FINISH
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       atn;
        logic       eoi;
    } tx_req_t;

    state_t           state, state_nxt;
    tx_req_t          req_q, req_nxt;
    logic [2:0]       bit_n, bit_nxt;
    logic [1:0]       status_q, status_nxt;
    logic             done_q;
    logic             atn_q, clk_q, data_q;
    logic             atn_d, clk_d, data_d;
    logic [1:0]       clk_sync, data_sync;
    logic             clk_s, data_s;
    logic [PRE_W-1:0] pre_cnt;
    logic [13:0]      us_cnt, us_inc;
    logic [1:0]       age;
    logic             entry, tick, settled;
    logic             exp_bit, exp_ack, exp_eoi, exp_rdy;

    assign tx_ready   = (state == S_IDLE);
    assign done       = done_q;
    assign status     = status_q;
    assign iec_atn_o  = atn_q;
    assign iec_clk_o  = clk_q;
    assign iec_data_o = data_q;

    assign clk_s   = clk_sync[1];
    assign data_s  = data_sync[1];
    assign entry   = (state_nxt != state);
    assign tick    = ce && (pre_cnt == PRE_W'(CE_PER_US - 1));
    // Bus inputs lag our own line changes by the synchroniser, so only trust
    // them once a state has been held long enough for that lag to flush.
    assign settled = (age == 2'd3);

    // Elapsed-µs value after the current tick: a phase expires on the tick
    // that brings it to the limit, so phase length is exactly limit µs.
    assign us_inc  = (us_cnt == US_MAX) ? us_cnt : us_cnt + 14'd1;
    assign exp_bit = tick && (us_inc >= L_BIT);
    assign exp_ack = tick && (us_inc >= L_ACK);
    assign exp_eoi = tick && (us_inc >= L_EOI);
    assign exp_rdy = tick && (us_inc >= L_READY);

    // Double-flop synchronisers for the wired-AND bus levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], iec_clk_i};
            data_sync <= {data_sync[0], iec_data_i};
        end
    end

    // µs prescaler, µs counter and settle age; all restart on state entry so
    // every phase begins on a µs boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
            age     <= '0;
        end else if (entry) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
            age     <= '0;
        end else begin
            if (ce) pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
            if (tick) us_cnt <= us_inc;
            if (!settled) age <= age + 2'd1;
        end
    end

    // State, request latch, bit index, status, done pulse and line drivers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            req_q    <= '0;
            bit_n    <= '0;
            status_q <= ST_OK;
            done_q   <= 1'b0;
            atn_q    <= 1'b1;
            clk_q    <= 1'b1;
            data_q   <= 1'b1;
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            bit_n    <= bit_nxt;
            status_q <= status_nxt;
            done_q   <= (state == S_FINISH) && (state_nxt == S_IDLE);
            atn_q    <= atn_d;
            clk_q    <= clk_d;
            data_q   <= data_d;
        end
    end

    // Next-state logic; listener responses are checked before timeouts so an
    // edge arriving on the expiry tick still counts as success.
    always_comb begin
        state_nxt  = state;
        req_nxt    = req_q;
        bit_nxt    = bit_n;
        status_nxt = status_q;
        case (state)
            S_IDLE: if (tx_valid) begin
                req_nxt.data = tx_data;
                req_nxt.atn  = tx_atn;
                req_nxt.eoi  = tx_eoi;
                status_nxt   = ST_OK;
                bit_nxt      = 3'd0;
                state_nxt    = tx_atn ? S_ATN_START : S_HOLD;
            end
            S_ATN_START: begin
                if (settled && !data_s) state_nxt = S_READY;
                else if (exp_ack) begin
                    status_nxt = ST_NODEV;
                    state_nxt  = S_FINISH;
                end
            end
            S_HOLD: if (exp_bit) state_nxt = S_READY;
            // Bus CLK must also read released: nobody else may be holding it.
            S_READY: begin
                if (settled && data_s && clk_s) state_nxt = req_q.eoi ? S_EOI_LOW : S_BIT_LOW;
                else if (exp_rdy) begin
                    status_nxt = ST_TIMEOUT;
                    state_nxt  = S_FINISH;
                end
            end
            S_EOI_LOW: begin
                if (settled && !data_s) state_nxt = S_EOI_HIGH;
                else if (exp_eoi) begin
                    status_nxt = ST_NOACK;
                    state_nxt  = S_FINISH;
                end
            end
            S_EOI_HIGH: begin
                if (settled && data_s) state_nxt = S_BIT_LOW;
                else if (exp_eoi) begin
                    status_nxt = ST_NOACK;
                    state_nxt  = S_FINISH;
                end
            end
            S_BIT_LOW: if (exp_bit) state_nxt = S_BIT_HIGH;
            S_BIT_HIGH: if (exp_bit) begin
                if (bit_n == 3'd7) state_nxt = S_ACK_WAIT;
                else begin
                    bit_nxt   = bit_n + 3'd1;
                    state_nxt = S_BIT_LOW;
                end
            end
            S_ACK_WAIT: begin
                if (settled && !data_s) begin
                    status_nxt = ST_OK;
                    state_nxt  = S_FINISH;
                end else if (exp_ack) begin
                    status_nxt = ST_NOACK;
                    state_nxt  = S_FINISH;
                end
            end
            // A command byte keeps ATN asserted one bit time past the frame;
            // error paths that released the bus finish at once.
            S_FINISH: begin
                if (req_q.atn && !status_q[0]) begin
                    if (exp_bit) state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Line levels for the state being entered; IDLE holds whatever was left
    // (CLK stays low between bytes) except that ATN is always let go.
    always_comb begin
        atn_d  = atn_q;
        clk_d  = clk_q;
        data_d = data_q;
        case (state_nxt)
            S_IDLE: if (state == S_FINISH) atn_d = 1'b1;
            S_ATN_START: begin
                atn_d  = 1'b0;
                clk_d  = 1'b0;
                data_d = 1'b1;
            end
            S_HOLD: begin
                clk_d  = 1'b0;
                data_d = 1'b1;
            end
            S_READY, S_EOI_LOW, S_EOI_HIGH: begin
                clk_d  = 1'b1;
                data_d = 1'b1;
            end
            S_BIT_LOW: begin
                clk_d  = 1'b0;
                data_d = req_q.data[bit_nxt];
            end
            S_BIT_HIGH: clk_d = 1'b1;
            S_ACK_WAIT: begin
                clk_d  = 1'b0;
                data_d = 1'b1;
            end
            S_FINISH: begin
                if (status_nxt[0]) begin
                    atn_d  = 1'b1;
                    clk_d  = 1'b1;
                    data_d = 1'b1;
                end else begin
                    clk_d  = 1'b0;
                    data_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iec_host_tx.sv
// Directed bench for iec_host_tx with a scaled-down timebase: ce every other
// clk, 2 ce per µs, so 1 µs = 4 clk. A listener is modelled by lst_data.
module tb_iec_host_tx;

    localparam int CPU     = 4;   // clk per µs
    localparam int T_BIT   = 6;
    localparam int T_ACK   = 40;
    localparam int T_EOI   = 25;
    localparam int T_READY = 200;
    localparam int HI_MIN  = T_BIT * CPU - 3;
    localparam int HI_MAX  = T_BIT * CPU + 3;

    logic       clk = 1'b0, reset_n = 1'b0, ce = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_atn = 1'b0, tx_eoi = 1'b0, tx_valid = 1'b0;
    logic       tx_ready, done;
    logic [1:0] status;
    logic       iec_atn_o, iec_clk_o, iec_data_o;
    logic       iec_clk_i, iec_data_i;
    logic       lst_data = 1'b1;

    int errors = 0, checks = 0;

    // monitor state
    int         cyc = 0, nbits = 0, ndone = 0, dchg = 0, hi = 0;
    int         atn_rise = 0, last_rise = 0, first_bit_rise = 0;
    logic [7:0] rx_byte = 8'h00;
    logic       p_clk = 1'b1, p_data = 1'b1, p_atn = 1'b1;

    iec_host_tx #(
        .CE_PER_US(2), .T_BIT_US(T_BIT), .T_ACK_US(T_ACK),
        .T_EOI_US(T_EOI), .T_READY_US(T_READY)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce(ce),
        .tx_data(tx_data), .tx_atn(tx_atn), .tx_eoi(tx_eoi), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .done(done), .status(status),
        .iec_atn_o(iec_atn_o), .iec_clk_o(iec_clk_o), .iec_data_o(iec_data_o),
        .iec_clk_i(iec_clk_i), .iec_data_i(iec_data_i)
    );

    assign iec_clk_i  = iec_clk_o;
    assign iec_data_i = iec_data_o & lst_data;

    always #5 clk = ~clk;
    always @(posedge clk) ce <= ~ce;

    // Bus monitor: records bits as CLK-high phases of one bit time, counts
    // done pulses and DATA changes while CLK is high; clears on each accept.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (tx_valid && tx_ready) begin
            nbits = 0; ndone = 0; dchg = 0; hi = 0; rx_byte = 8'h00;
        end else begin
            if (done) ndone = ndone + 1;
            if (iec_clk_o && p_clk && (iec_data_o != p_data)) dchg = dchg + 1;
            if (iec_clk_o && !p_clk) begin
                hi = 0;
                last_rise = cyc;
            end
            if (!iec_clk_o && p_clk && hi >= HI_MIN && hi <= HI_MAX && nbits < 8) begin
                if (nbits == 0) first_bit_rise = last_rise;
                rx_byte[3'(nbits)] = p_data;
                nbits = nbits + 1;
            end
            if (iec_clk_o) hi = hi + 1;
            if (iec_atn_o && !p_atn) atn_rise = cyc;
        end
        p_clk  = iec_clk_o;
        p_data = iec_data_o;
        p_atn  = iec_atn_o;
    end

    task automatic send(input logic [7:0] d, input logic a, input logic e, output int start);
        @(posedge clk); #1;
        tx_data = d; tx_atn = a; tx_eoi = e; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        start = cyc;
    endtask

    task automatic wait_bits(input int n, input int limit);
        for (int i = 0; i < limit && nbits < n; i++) @(negedge clk);
        checks++;
        if (nbits < n) begin
            errors++;
            $display("FAIL bits_timeout: got %0d bits, need %0d", nbits, n);
        end
    endtask

    task automatic wait_done(input int limit, output int dcyc);
        for (int i = 0; i < limit && done !== 1'b1; i++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d clk", limit);
        end
        dcyc = cyc;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 6;
        if (iec_atn_o !== 1'b1)  begin errors++; $display("FAIL rst_atn: got %b want 1", iec_atn_o); end
        if (iec_clk_o !== 1'b1)  begin errors++; $display("FAIL rst_clk: got %b want 1", iec_clk_o); end
        if (iec_data_o !== 1'b1) begin errors++; $display("FAIL rst_data: got %b want 1", iec_data_o); end
        if (tx_ready !== 1'b1)   begin errors++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
        if (done !== 1'b0)       begin errors++; $display("FAIL rst_done: got %b want 0", done); end
        if (status !== 2'b00)    begin errors++; $display("FAIL rst_status: got %b want 00", status); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Command byte 0x28: listener answers ATN after 10 µs, frees DATA, acks frame.
    task automatic test_atn_byte;
        int t0, tack, td;
        lst_data = 1'b1;
        send(8'h28, 1'b1, 1'b0, t0);
        for (int i = 0; i < 20 && iec_atn_o !== 1'b0; i++) @(negedge clk);
        checks++;
        if (iec_atn_o !== 1'b0) begin errors++; $display("FAIL atn_assert: got %b want 0", iec_atn_o); end
        repeat (10 * CPU) @(negedge clk);
        lst_data = 1'b0;
        repeat (5 * CPU) @(negedge clk);
        lst_data = 1'b1;
        wait_bits(8, 1000);
        repeat (5 * CPU) @(negedge clk);
        lst_data = 1'b0;
        tack = cyc;
        wait_done(400, td);
        repeat (3) @(negedge clk);
        checks += 7;
        if (rx_byte !== 8'h28)  begin errors++; $display("FAIL atn_byte: got %h want 28", rx_byte); end
        if (status !== 2'b00)   begin errors++; $display("FAIL atn_status: got %b want 00", status); end
        if (ndone !== 1)        begin errors++; $display("FAIL atn_done_cnt: got %0d want 1", ndone); end
        if (iec_atn_o !== 1'b1) begin errors++; $display("FAIL atn_release: got %b want 1", iec_atn_o); end
        if (iec_clk_o !== 1'b0) begin errors++; $display("FAIL atn_clk_left: got %b want 0", iec_clk_o); end
        if (atn_rise - tack < T_BIT * CPU - 2 || atn_rise - tack > T_BIT * CPU + 10) begin
            errors++; $display("FAIL atn_hold_time: got %0d clk want ~%0d", atn_rise - tack, T_BIT * CPU + 3);
        end
        if (dchg !== 0) begin errors++; $display("FAIL atn_data_stable: got %0d changes want 0", dchg); end
        lst_data = 1'b1;
    endtask

    // Data byte 0x55 with EOI: listener pulls DATA for 6 µs after 25 µs.
    task automatic test_eoi;
        int t0, trel, td;
        send(8'h55, 1'b0, 1'b1, t0);
        for (int i = 0; i < 200 && iec_clk_o !== 1'b1; i++) @(negedge clk);
        checks++;
        if (iec_clk_o !== 1'b1) begin errors++; $display("FAIL eoi_ready: got %b want 1", iec_clk_o); end
        repeat (T_EOI * CPU) @(negedge clk);
        lst_data = 1'b0;
        repeat (T_BIT * CPU) @(negedge clk);
        lst_data = 1'b1;
        trel = cyc;
        wait_bits(8, 1000);
        repeat (5 * CPU) @(negedge clk);
        lst_data = 1'b0;
        wait_done(400, td);
        repeat (3) @(negedge clk);
        checks += 6;
        if (rx_byte !== 8'h55)  begin errors++; $display("FAIL eoi_byte: got %h want 55", rx_byte); end
        if (status !== 2'b00)   begin errors++; $display("FAIL eoi_status: got %b want 00", status); end
        if (iec_clk_o !== 1'b0) begin errors++; $display("FAIL eoi_clk_left: got %b want 0", iec_clk_o); end
        if (iec_atn_o !== 1'b1) begin errors++; $display("FAIL eoi_atn: got %b want 1", iec_atn_o); end
        if (first_bit_rise <= trel) begin
            errors++; $display("FAIL eoi_order: bit0 at %0d, release at %0d", first_bit_rise, trel);
        end
        if (ndone !== 1) begin errors++; $display("FAIL eoi_done_cnt: got %0d want 1", ndone); end
        lst_data = 1'b1;
    endtask

    // Byte 0xA3, listener never acks the frame.
    task automatic test_no_frame_ack;
        int t0, tb8, td;
        lst_data = 1'b1;
        send(8'hA3, 1'b0, 1'b0, t0);
        wait_bits(8, 1000);
        tb8 = cyc;
        wait_done(400, td);
        repeat (2) @(negedge clk);
        checks += 5;
        if (rx_byte !== 8'hA3)   begin errors++; $display("FAIL noack_byte: got %h want a3", rx_byte); end
        if (status !== 2'b10)    begin errors++; $display("FAIL noack_status: got %b want 10", status); end
        if (td - tb8 < T_ACK * CPU - 10 || td - tb8 > T_ACK * CPU + 12) begin
            errors++; $display("FAIL noack_time: got %0d clk want ~%0d", td - tb8, T_ACK * CPU);
        end
        if (iec_clk_o !== 1'b0)  begin errors++; $display("FAIL noack_clk: got %b want 0", iec_clk_o); end
        if (iec_data_o !== 1'b1) begin errors++; $display("FAIL noack_data: got %b want 1", iec_data_o); end
    endtask

    // Listener holds DATA low throughout: ready timeout after T_READY.
    task automatic test_ready_timeout;
        int t0, td, want;
        want = (T_BIT + T_READY) * CPU;
        lst_data = 1'b0;
        send(8'h3C, 1'b0, 1'b0, t0);
        wait_done(1200, td);
        repeat (2) @(negedge clk);
        checks += 6;
        if (status !== 2'b11) begin errors++; $display("FAIL rdy_status: got %b want 11", status); end
        if (td - t0 < want - 6 || td - t0 > want + 12) begin
            errors++; $display("FAIL rdy_time: got %0d clk want ~%0d", td - t0, want);
        end
        if (iec_atn_o !== 1'b1)  begin errors++; $display("FAIL rdy_atn: got %b want 1", iec_atn_o); end
        if (iec_clk_o !== 1'b1)  begin errors++; $display("FAIL rdy_clk: got %b want 1", iec_clk_o); end
        if (iec_data_o !== 1'b1) begin errors++; $display("FAIL rdy_data: got %b want 1", iec_data_o); end
        if (nbits !== 0)         begin errors++; $display("FAIL rdy_bits: got %0d want 0", nbits); end
        lst_data = 1'b1;
    endtask

    // Command byte with nobody on the bus.
    task automatic test_no_device;
        int t0, td, want;
        want = T_ACK * CPU;
        lst_data = 1'b1;
        send(8'h3F, 1'b1, 1'b0, t0);
        wait_done(400, td);
        repeat (2) @(negedge clk);
        checks += 5;
        if (status !== 2'b01) begin errors++; $display("FAIL nodev_status: got %b want 01", status); end
        if (td - t0 < want - 6 || td - t0 > want + 12) begin
            errors++; $display("FAIL nodev_time: got %0d clk want ~%0d", td - t0, want);
        end
        if (iec_atn_o !== 1'b1)  begin errors++; $display("FAIL nodev_atn: got %b want 1", iec_atn_o); end
        if (iec_clk_o !== 1'b1)  begin errors++; $display("FAIL nodev_clk: got %b want 1", iec_clk_o); end
        if (iec_data_o !== 1'b1) begin errors++; $display("FAIL nodev_data: got %b want 1", iec_data_o); end
    endtask

    // Reset during BIT_HIGH of bit 3, then a normal byte.
    task automatic test_reset_mid;
        int t0, td;
        lst_data = 1'b1;
        send(8'h0F, 1'b0, 1'b0, t0);
        wait_bits(3, 800);
        for (int i = 0; i < 60 && iec_clk_o !== 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks += 5;
        if (iec_atn_o !== 1'b1)  begin errors++; $display("FAIL mid_atn: got %b want 1", iec_atn_o); end
        if (iec_clk_o !== 1'b1)  begin errors++; $display("FAIL mid_clk: got %b want 1", iec_clk_o); end
        if (iec_data_o !== 1'b1) begin errors++; $display("FAIL mid_data: got %b want 1", iec_data_o); end
        if (tx_ready !== 1'b1)   begin errors++; $display("FAIL mid_ready: got %b want 1", tx_ready); end
        if (done !== 1'b0)       begin errors++; $display("FAIL mid_done: got %b want 0", done); end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (ndone !== 0) begin errors++; $display("FAIL mid_no_done: got %0d want 0", ndone); end
        send(8'h81, 1'b0, 1'b0, t0);
        wait_bits(8, 1000);
        repeat (5 * CPU) @(negedge clk);
        lst_data = 1'b0;
        wait_done(400, td);
        repeat (3) @(negedge clk);
        checks += 3;
        if (rx_byte !== 8'h81) begin errors++; $display("FAIL post_byte: got %h want 81", rx_byte); end
        if (status !== 2'b00)  begin errors++; $display("FAIL post_status: got %b want 00", status); end
        if (ndone !== 1)       begin errors++; $display("FAIL post_done_cnt: got %0d want 1", ndone); end
        lst_data = 1'b1;
    endtask

    initial begin
        test_reset;
        test_atn_byte;
        test_eoi;
        test_no_frame_ack;
        test_ready_timeout;
        test_no_device;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
